// File: rtl/pac_gen_if.sv
// pac_gen_if: phase-in / amplitude-out stream with flow control, plus the
// coarse-table write port. Master drives phases and table writes; slave is
// the converter.
interface pac_gen_if #(
  parameter int OW = 16,
  parameter int TW = 6,
  parameter int NS = 7
);
  localparam int PW = 2 + TW + NS;

  logic                 in_valid;
  logic                 in_ready;
  logic [PW-1:0]        phase;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] sin_out;
  logic signed [OW-1:0] cos_out;
  logic                 tbl_we;
  logic [TW-1:0]        tbl_addr;
  logic [2*OW-1:0]      tbl_wdata;

  modport master (
    output in_valid, phase, out_ready, tbl_we, tbl_addr, tbl_wdata,
    input  in_ready, out_valid, sin_out, cos_out
  );

  modport slave (
    input  in_valid, phase, out_ready, tbl_we, tbl_addr, tbl_wdata,
    output in_ready, out_valid, sin_out, cos_out
  );
endinterface

// File: rtl/pac_gen.sv
// pac_gen: phase-to-amplitude converter. Coarse cos/sin table lookup on the
// first-quadrant index, NS shift-add rotation stages driven by the residual
// bits (MSB first), then saturation and quadrant mirroring.
// Optional feature macro: PAC_GEN_COS_EN -- when undefined cos_out is tied
// to zero and the cosine mirror is not built (the x path is still needed by
// the rotation and by the q1/q3 sine mapping).
module pac_gen #(
  parameter int OW         = 16,
  parameter int TW         = 6,
  parameter int NS         = 7,
  parameter int BASE_SHIFT = 6
) (
  input logic      clk,
  input logic      reset,   // asynchronous, active low
  pac_gen_if.slave bus
);
  localparam int PW    = 2 + TW + NS;
  localparam int XW    = OW + 2;
  localparam int DEPTH = 1 << TW;
  localparam logic signed [OW-1:0] SMAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] SMIN = {1'b1, {(OW-1){1'b0}}};

  logic out_valid_q, out_valid_d;
  logic en;
  logic accept;

  // Whole pipeline advances only when the output slot is free or draining.
  assign en           = bus.out_ready || !out_valid_q;
  // A table write steals the single RAM port, so it blocks acceptance.
  assign bus.in_ready = en && !bus.tbl_we;
  assign accept       = bus.in_valid && bus.in_ready;

  // ---------------------------------------------------------------------
  // Coarse table: single-port RAM, word = {cos, sin}, not reset.
  // ---------------------------------------------------------------------
  logic [2*OW-1:0] tbl_mem [DEPTH];
  logic [2*OW-1:0] tbl_rd_q;

  // Write has priority; read only on an accepted sample so a stall holds data.
  always_ff @(posedge clk) begin
    if (bus.tbl_we) begin
      tbl_mem[bus.tbl_addr] <= bus.tbl_wdata;
    end else if (accept) begin
      tbl_rd_q <= tbl_mem[bus.phase[NS +: TW]];
    end
  end

  // ---------------------------------------------------------------------
  // Stage T side-band: quadrant, residual and valid travel with the read.
  // ---------------------------------------------------------------------
  logic          t_valid_q, t_valid_d;
  logic [1:0]    t_quad_q, t_quad_d;
  logic [NS-1:0] t_res_q, t_res_d;

  // Capture side-band of the sample entering the table read.
  always_comb begin
    t_valid_d = t_valid_q;
    t_quad_d  = t_quad_q;
    t_res_d   = t_res_q;
    if (en) begin
      t_valid_d = accept;
      t_quad_d  = bus.phase[PW-1 -: 2];
      t_res_d   = bus.phase[NS-1:0];
    end
  end

  // Stage T side-band registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_valid_q <= 1'b0;
      t_quad_q  <= '0;
      t_res_q   <= '0;
    end else begin
      t_valid_q <= t_valid_d;
      t_quad_q  <= t_quad_d;
      t_res_q   <= t_res_d;
    end
  end

  // Stage boundary nets: index k is the input of rotation stage k.
  logic signed [XW-1:0] x_s [NS+1];
  logic signed [XW-1:0] y_s [NS+1];
  logic [1:0]           q_s [NS+1];
  logic                 v_s [NS+1];
  logic [NS-1:0]        r_s [NS];

  assign x_s[0] = {{2{tbl_rd_q[2*OW-1]}}, tbl_rd_q[2*OW-1:OW]};
  assign y_s[0] = {{2{tbl_rd_q[OW-1]}}, tbl_rd_q[OW-1:0]};
  assign q_s[0] = t_quad_q;
  assign v_s[0] = t_valid_q;
  assign r_s[0] = t_res_q;

  // ---------------------------------------------------------------------
  // Rotation stages: stage gi consumes residual bit NS-1-gi, shift BASE+gi.
  // ---------------------------------------------------------------------
  genvar gi;
  for (gi = 0; gi < NS; gi++) begin : g_rot
    localparam int SH = BASE_SHIFT + gi;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d;
    logic [1:0]           q_q, q_d;
    logic                 v_q, v_d;

    // Conditional micro-rotation; both updates use the pre-stage x and y.
    always_comb begin
      x_d = x_q;
      y_d = y_q;
      q_d = q_q;
      v_d = v_q;
      if (en) begin
        v_d = v_s[gi];
        q_d = q_s[gi];
        if (r_s[gi][NS-1-gi]) begin
          x_d = x_s[gi] - (y_s[gi] >>> SH);
          y_d = y_s[gi] + (x_s[gi] >>> SH);
        end else begin
          x_d = x_s[gi];
          y_d = y_s[gi];
        end
      end
    end

    // Rotation stage registers.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        x_q <= '0;
        y_q <= '0;
        q_q <= '0;
        v_q <= 1'b0;
      end else begin
        x_q <= x_d;
        y_q <= y_d;
        q_q <= q_d;
        v_q <= v_d;
      end
    end

    assign x_s[gi+1] = x_q;
    assign y_s[gi+1] = y_q;
    assign q_s[gi+1] = q_q;
    assign v_s[gi+1] = v_q;

    // The residual only needs to reach stages that still consume a bit.
    if (gi < NS - 1) begin : g_res
      logic [NS-1:0] r_q, r_d;

      // Forward the residual alongside the data.
      always_comb begin
        r_d = r_q;
        if (en) r_d = r_s[gi];
      end

      // Residual register.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_q <= '0;
        else        r_q <= r_d;
      end

      assign r_s[gi+1] = r_q;
    end
  end

  // ---------------------------------------------------------------------
  // Output stage: saturate to OW, then mirror by quadrant.
  // ---------------------------------------------------------------------
  function automatic logic signed [OW-1:0] sat(input logic signed [XW-1:0] v);
    if (v[XW-1:OW-1] == {(XW-OW+1){v[XW-1]}}) return v[OW-1:0];
    return v[XW-1] ? SMIN : SMAX;
  endfunction

  // Negating the most negative value would wrap, so clamp it instead.
  function automatic logic signed [OW-1:0] neg(input logic signed [OW-1:0] v);
    return (v == SMIN) ? SMAX : -v;
  endfunction

  logic signed [OW-1:0] xs, ys;
  logic signed [OW-1:0] sin_q, sin_d;

  assign xs = sat(x_s[NS]);
  assign ys = sat(y_s[NS]);

  // Sine mirror; data only updates on a valid sample so bubbles keep the last value.
  always_comb begin
    out_valid_d = out_valid_q;
    sin_d       = sin_q;
    if (en) begin
      out_valid_d = v_s[NS];
      if (v_s[NS]) begin
        case (q_s[NS])
          2'd0:    sin_d = ys;
          2'd1:    sin_d = xs;
          2'd2:    sin_d = neg(ys);
          default: sin_d = neg(xs);
        endcase
      end
    end
  end

  // Output valid and sine registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      sin_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      sin_q       <= sin_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sin_out   = sin_q;

`ifdef PAC_GEN_COS_EN
  logic signed [OW-1:0] cos_q, cos_d;

  // Cosine mirror, updated under the same conditions as the sine.
  always_comb begin
    cos_d = cos_q;
    if (en && v_s[NS]) begin
      case (q_s[NS])
        2'd0:    cos_d = xs;
        2'd1:    cos_d = neg(ys);
        2'd2:    cos_d = neg(xs);
        default: cos_d = ys;
      endcase
    end
  end

  // Cosine output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cos_q <= '0;
    else        cos_q <= cos_d;
  end

  assign bus.cos_out = cos_q;
`else
  assign bus.cos_out = '0;
`endif

endmodule

// File: tb/tb_pac_gen.sv
// tb_pac_gen: directed vector table for pac_gen plus hand-written sequences
// for stall, table-write collision, in-flight table update and reset.
module tb_pac_gen;
  localparam int OW = 16;
  localparam int TW = 6;
  localparam int NS = 7;
  localparam int PW = 2 + TW + NS;
  localparam int NV = 12;
  localparam int LAT_AFTER = NS + 1;  // edges after the accepting edge

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pac_gen_if #(.OW(OW), .TW(TW), .NS(NS)) bus ();

  pac_gen #(.OW(OW), .TW(TW), .NS(NS), .BASE_SHIFT(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [TW-1:0] addr;
    logic [OW-1:0] tcos;
    logic [OW-1:0] tsin;
    logic [PW-1:0] phase;
    logic [OW-1:0] esin;
    logic [OW-1:0] ecos;
  } vec_t;

  vec_t vecs [NV];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] exp_cos(input logic [OW-1:0] c);
`ifdef PAC_GEN_COS_EN
    return c;
`else
    return (c & 16'h0000);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic tbl_write(input logic [TW-1:0] a, input logic [OW-1:0] c, input logic [OW-1:0] s);
    bus.tbl_we    = 1'b1;
    bus.tbl_addr  = a;
    bus.tbl_wdata = {c, s};
    tick();
    bus.tbl_we    = 1'b0;
  endtask

  // Feed one sample, wait for its result and check latency and values.
  task automatic run_one(input string tag, input logic [PW-1:0] ph,
                         input logic [OW-1:0] es, input logic [OW-1:0] ec);
    int cyc;
    bus.phase    = ph;
    bus.in_valid = 1'b1;
    #1;
    chk_int({tag, " in_ready"}, int'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    wait_out(cyc);
    chk_int({tag, " latency"}, cyc, LAT_AFTER);
    chk({tag, " sin"}, bus.sin_out, es);
    chk({tag, " cos"}, bus.cos_out, exp_cos(ec));
    $display("%s phase=%h sin=%h cos=%h lat=%0d", tag, ph, bus.sin_out, bus.cos_out, cyc + 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_q[$];
    int sent, got, cyc, stale;

    //          addr  tcos      tsin      phase      esin      ecos
    vecs[0]  = '{6'd0, 16'h4000, 16'h0000, 15'h0000, 16'h0000, 16'h4000};
    vecs[1]  = '{6'd0, 16'h4000, 16'h0000, 15'h0040, 16'h0100, 16'h4000};
    vecs[2]  = '{6'd0, 16'h4000, 16'h0000, 15'h2040, 16'h4000, 16'hFF00};
    vecs[3]  = '{6'd0, 16'h4000, 16'h0000, 15'h4040, 16'hFF00, 16'hC000};
    vecs[4]  = '{6'd0, 16'h4000, 16'h0000, 15'h6040, 16'hC000, 16'h0100};
    vecs[5]  = '{6'd5, 16'h7FFF, 16'h7FFF, 15'h02C0, 16'h7FFF, 16'h7E00};
    vecs[6]  = '{6'd1, 16'h8000, 16'h8000, 15'h4080, 16'h7FFF, 16'h7FFF};
    vecs[7]  = '{6'd2, 16'h4000, 16'h2000, 15'h0101, 16'h2004, 16'h3FFE};
    vecs[8]  = '{6'd3, 16'h4000, 16'hFFFF, 15'h01C0, 16'h00FF, 16'h4001};
    vecs[9]  = '{6'd0, 16'h4000, 16'h0000, 15'h0060, 16'h0180, 16'h3FFE};
    vecs[10] = '{6'd1, 16'h8000, 16'h8000, 15'h6080, 16'h7FFF, 16'h8000};
    vecs[11] = '{6'd1, 16'h8000, 16'h8000, 15'h2080, 16'h8000, 16'h7FFF};

    bus.in_valid  = 1'b0;
    bus.phase     = '0;
    bus.out_ready = 1'b1;
    bus.tbl_we    = 1'b0;
    bus.tbl_addr  = '0;
    bus.tbl_wdata = '0;

    // Reset state.
    tick();
    tick();
    chk_int("rst out_valid", int'(bus.out_valid), 0);
    chk("rst sin", bus.sin_out, 16'h0000);
    chk("rst cos", bus.cos_out, 16'h0000);
    chk_int("rst in_ready", int'(bus.in_ready), 1);
    reset = 1'b1;
    tick();

    // Load the table, then run the directed vectors one at a time.
    for (int i = 0; i < NV; i++) tbl_write(vecs[i].addr, vecs[i].tcos, vecs[i].tsin);
    for (int i = 0; i < NV; i++)
      run_one($sformatf("vec%0d", i), vecs[i].phase, vecs[i].esin, vecs[i].ecos);

    // Back-to-back stream of 20 with a 5-cycle out_ready stall.
    sent = 0;
    got  = 0;
    for (int c = 0; c < 200 && got < 20; c++) begin
      bus.out_ready = !(c >= 10 && c < 15);
      bus.in_valid  = (sent < 20);
      bus.phase     = vecs[sent % NV].phase;
      #1;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(sent % NV);
        sent++;
      end
      if (bus.out_valid && !bus.out_ready) begin
        chk_int("stall in_ready", int'(bus.in_ready), 0);
        if (exp_q.size() > 0) begin
          chk("stall sin", bus.sin_out, vecs[exp_q[0]].esin);
          chk("stall cos", bus.cos_out, exp_cos(vecs[exp_q[0]].ecos));
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk_int("stream extra output", 1, 0);
        end else begin
          chk("stream sin", bus.sin_out, vecs[exp_q[0]].esin);
          chk("stream cos", bus.cos_out, exp_cos(vecs[exp_q[0]].ecos));
          $display("stream out %0d vec%0d sin=%h cos=%h", got, exp_q[0], bus.sin_out, bus.cos_out);
          void'(exp_q.pop_front());
          got++;
        end
      end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk_int("stream received", got, 20);
    chk_int("stream sent", sent, 20);

    // Table write colliding with a valid sample: write wins, sample waits.
    tbl_write(6'd4, 16'h1000, 16'h0800);
    bus.phase     = 15'h0200;
    bus.in_valid  = 1'b1;
    bus.tbl_we    = 1'b1;
    bus.tbl_addr  = 6'd4;
    bus.tbl_wdata = {16'h2000, 16'h0300};
    #1;
    chk_int("coll in_ready", int'(bus.in_ready), 0);
    tick();
    bus.tbl_we = 1'b0;
    #1;
    chk_int("coll in_ready next", int'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    wait_out(cyc);
    chk_int("coll latency", cyc, LAT_AFTER);
    chk("coll sin", bus.sin_out, 16'h0300);
    chk("coll cos", bus.cos_out, exp_cos(16'h2000));
    $display("collision sin=%h cos=%h", bus.sin_out, bus.cos_out);
    tick();
    chk_int("coll no duplicate", int'(bus.out_valid), 0);

    // Write right after acceptance: in-flight sample keeps the old word.
    bus.phase    = 15'h0200;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tbl_write(6'd4, 16'h3000, 16'h0500);
    wait_out(cyc);
    chk("inflight sin", bus.sin_out, 16'h0300);
    chk("inflight cos", bus.cos_out, exp_cos(16'h2000));
    tick();
    run_one("after write", 15'h0200, 16'h0500, 16'h3000);

    // Reset with four samples in flight.
    for (int i = 0; i < 4; i++) begin
      bus.phase    = vecs[i].phase;
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk_int("midrst out_valid", int'(bus.out_valid), 0);
    chk("midrst sin", bus.sin_out, 16'h0000);
    chk("midrst cos", bus.cos_out, 16'h0000);
    tick();
    tick();
    reset = 1'b1;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid) stale++;
    end
    chk_int("midrst stale outputs", stale, 0);
    run_one("post reset", vecs[7].phase, vecs[7].esin, vecs[7].ecos);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pac_gen.md
# pac_gen

Parametrised phase-to-amplitude converter, successor to the fixed 64-entry / 7-stage PAC pipeline. It sits in the DDS datapath between the phase accumulator and the DAC formatter. A loadable coarse table supplies cos and sin of the first-quadrant angle, an NS-stage shift-add rotation pipeline refines it, and a quadrant mirror produces signed sine and cosine. Unlike its predecessor it has valid/ready flow control with back-pressure and a table write port that arbitrates against traffic.

## Interface
- OW, 16, output and table sample width (signed)
- TW, 6, table address bits; table depth is 2^TW
- NS, 7, rotation stages, one per residual phase bit
- BASE_SHIFT, 6, arithmetic shift of stage 0; stage k shifts by BASE_SHIFT+k
- Derived (localparam): PW = 2+TW+NS, the phase width (15 at defaults)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous active-low reset
- in_valid  in  1  phase sample valid
- in_ready  out  1  sample accepted when in_valid && in_ready
- phase  in  PW  bit field {quadrant[1:0], index[TW-1:0], residual[NS-1:0]}
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- sin_out  out  OW  signed sine
- cos_out  out  OW  signed cosine
- tbl_we  in  1  table write strobe
- tbl_addr  in  TW  table write address
- tbl_wdata  in  2*OW  table word, {cos[OW-1:0], sin[OW-1:0]}, both signed

## Operation
- Global enable: en = out_ready || !out_valid. When en=0, every pipeline register holds, including the table read register.
- in_ready = en && !tbl_we. A table write has priority; it blocks acceptance for that cycle and completes in one cycle.
- The table is a single-port synchronous RAM, 2^TW x 2*OW. It is not reset. It is read at phase.index on acceptance.
- Stage T (table register):
  - x = cos, y = sin, sign-extended to OW+2 bits.
  - quadrant and residual travel alongside.
  - valid_T = accepted sample.
- Rotation stage k (k=0..NS-1), driven by residual[NS-1-k]:
  - bit set: x' = x - (y >>> (BASE_SHIFT+k)), y' = y + (x >>> (BASE_SHIFT+k)). Both updates use the pre-stage x and y. Arithmetic is OW+2 bits, two's complement, and the shift truncates toward negative infinity.
  - bit clear: x' = x, y' = y.
- Mirror/output stage: saturate x and y to OW signed, then map by quadrant:
  - q0: sin=y, cos=x
  - q1: sin=x, cos=-y
  - q2: sin=-y, cos=-x
  - q3: sin=-x, cos=y
  - Negation saturates: -(-2^(OW-1)) = 2^(OW-1)-1.
- Table gain and quantisation compensation belong to table content; the block does not correct them.

## Timing
- Latency is NS+2 accepted-to-valid cycles with no stall: 1 table read, NS rotation stages, 1 output stage. That is 9 cycles at defaults.
- Throughput is one sample per clock while en=1 and tbl_we=0.
- Reset values:
  - out_valid=0, sin_out=0, cos_out=0.
  - All internal valid bits = 0.
  - in_ready follows its combinational equation, so it reads 1 during reset if tbl_we=0.
- Reset mid-operation: all in-flight samples are discarded. No output is produced for them.
- out_valid && !out_ready: sin_out and cos_out stay stable until the handshake completes.
- Simultaneous tbl_we and in_valid: the write occurs, the sample is not accepted, and upstream must hold the sample.
- Write to an address already read into the pipeline: in-flight samples keep old data. Samples accepted after the write cycle see new data.
- Bubbles (valid=0) propagate through the pipeline. Their data is don't-care, but outputs are held at the last valid value.

## Configuration
- PAC_GEN_COS_EN
  - Defined: cos_out is computed as described.
  - Undefined: cos_out is constant 0 and the cos mirror/saturation logic is removed. The x path is still computed, because the rotation needs it.
  - All other behaviour and latency are identical in both builds.

## Test plan
All tests use default parameters.
- Table[0] = {0x4000, 0x0000}; phase 0x0000 accepted with out_ready=1 -> after 9 cycles, out_valid=1, sin_out=0x0000, cos_out=0x4000.
- Same table; phase 0x0040 (residual bit 6 set) -> sin_out=0x0100, cos_out=0x4000. Then phase 0x2040 (q1) -> sin_out=0x4000, cos_out=0xFF00.
- Table[0] = {0x7FFF, 0x7FFF}; phase 0x0040 -> sin_out=0x7FFF (saturated), cos_out=0x7E00.
- Stream of 20 back-to-back phases, with out_ready low for 5 cycles mid-stream -> no loss or duplication, outputs held stable while stalled, in_ready=0 while stalled.
- tbl_we asserted with in_valid=1 -> in_ready=0 that cycle, the write lands, and the held sample is accepted next cycle and uses the new word.
- reset pulsed low with 4 samples in flight -> out_valid=0 immediately and no stale outputs appear afterward. Table contents are preserved.
